ahb_cpu_dma_arbiter: RTL and testbench

Two-master AHB-Lite arbiter that shares the single CPU/DMA write slave between the CPU master (M0) and the DMA master (M1). It grants ownership of the address phase, multiplexes address/control and write data to the slave, and keeps fixed-length bursts atomic with a beat counter. It sits between the two master ports and the slave's HADDR/HTRANS/HWDATA inputs; the slave's HREADYOUT feeds back as HREADY.

---
 rtl/ahb3lite_pkg.sv | 41 ++++
 rtl/ahb_burst_beat_counter.sv | 34 +++
 rtl/ahb_cpu_dma_arbiter.sv | 123 ++++++++++++
 tb/tb_ahb_cpu_dma_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types plus the CPU/DMA arbiter owner encoding and burst-length constants.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_Type;

  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } arb_owner_e;

  localparam int BEATS_INCR4  = 4;
  localparam int BEATS_INCR8  = 8;
  localparam int BEATS_INCR16 = 16;

  // Beats still to come after the NONSEQ of a counted burst; 0 means "not counted".
  function automatic logic [3:0] burst_reload(input HBURST_Type burst);
    case (burst)
      INCR4:   return 4'(BEATS_INCR4 - 1);
      INCR8:   return 4'(BEATS_INCR8 - 1);
      INCR16:  return 4'(BEATS_INCR16 - 1);
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_beat_counter.sv
// Remaining-beat counter that keeps fixed-length INCR4/8/16 bursts atomic on the shared slave.
module ahb_burst_beat_counter
  import ahb3lite_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  HTRANS_state HTRANS,
  input  HBURST_Type  HBURST,
  output logic [3:0]  count,
  output logic        burst_active
);

  logic [3:0] reload;

  // burst_active flags a counted burst being launched in this very cycle.
  always_comb begin
    reload       = burst_reload(HBURST);
    burst_active = HREADY && (HTRANS == NONSEQ) && (reload != 4'd0);
  end

  // NOTE: state lives in always_ff with non-blocking assignments and an async
  // reset in the sensitivity list; blocking assignments here would race with readers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count <= 4'd0;
    end else if (burst_active) begin
      count <= reload;
    end else if (HREADY && (HTRANS == SEQ) && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/ahb_cpu_dma_arbiter.sv
// Two-master (CPU/DMA) AHB-Lite arbiter with address/data muxing and atomic fixed bursts.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed DMA priority.
module ahb_cpu_dma_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cpu_req,
  input  logic              dma_req,
  output logic              cpu_grant,
  output logic              dma_grant,
  input  logic [ADDR_W-1:0] cpu_HADDR,
  input  logic [ADDR_W-1:0] dma_HADDR,
  input  HTRANS_state       cpu_HTRANS,
  input  HTRANS_state       dma_HTRANS,
  input  HBURST_Type        cpu_HBURST,
  input  HBURST_Type        dma_HBURST,
  input  logic              cpu_HWRITE,
  input  logic              dma_HWRITE,
  input  logic [2:0]        cpu_HSIZE,
  input  logic [2:0]        dma_HSIZE,
  input  logic [DATA_W-1:0] cpu_HWDATA,
  input  logic [DATA_W-1:0] dma_HWDATA,
  output logic [ADDR_W-1:0] HADDR,
  output HTRANS_state       HTRANS,
  output HBURST_Type        HBURST,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output arb_owner_e        HMASTER,
  output arb_owner_e        data_owner
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_state_e;

  owner_state_e state_q, state_d;
  arb_owner_e   winner;
  logic         owner_req;
  logic         arb_point;
  logic         burst_active;
  logic [3:0]   beat_count;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= OWN_CPU;
    else          state_q <= state_d;
  end

  always_comb begin
    HMASTER   = (state_q == OWN_DMA) ? DMA : CPU;
    cpu_grant = (state_q == OWN_CPU);
    dma_grant = (state_q == OWN_DMA);
  end

  // An ungranted-but-owning master with req low is presented to the slave as IDLE.
  always_comb begin
    if (HMASTER == DMA) begin
      owner_req = dma_req;
      HADDR     = dma_HADDR;
      HTRANS    = dma_HTRANS;
      HBURST    = dma_HBURST;
      HWRITE    = dma_HWRITE;
      HSIZE     = dma_HSIZE;
    end else begin
      owner_req = cpu_req;
      HADDR     = cpu_HADDR;
      HTRANS    = cpu_HTRANS;
      HBURST    = cpu_HBURST;
      HWRITE    = cpu_HWRITE;
      HSIZE     = cpu_HSIZE;
    end
    if (!owner_req) HTRANS = IDLE;
  end

  assign HWDATA = (data_owner == DMA) ? dma_HWDATA : cpu_HWDATA;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    data_owner <= CPU;
    else if (HREADY) data_owner <= HMASTER;
  end

  ahb_burst_beat_counter u_beat (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HREADY       (HREADY),
    .HTRANS       (HTRANS),
    .HBURST       (HBURST),
    .count        (beat_count),
    .burst_active (burst_active)
  );

  // HTRANS is already forced to IDLE when the owner's req is low.
  assign arb_point = HREADY && (beat_count == 4'd0) && !burst_active && (HTRANS == IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e last_served;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                              last_served <= CPU;
    else if (arb_point && (cpu_req || dma_req)) last_served <= winner;
  end
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    winner  = CPU;
    state_d = state_q;
    case ({cpu_req, dma_req})
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   winner = (last_served == DMA) ? CPU : DMA;
`else
      2'b11:   winner = DMA;
`endif
      2'b01:   winner = DMA;
      default: winner = CPU;
    endcase
    if (arb_point) state_d = (winner == DMA) ? OWN_DMA : OWN_CPU;
  end

endmodule

// File: tb/tb_ahb_cpu_dma_arbiter.sv
// Directed, table-driven bench for ahb_cpu_dma_arbiter plus contention and reset sequences.
module tb_ahb_cpu_dma_arbiter;
  import ahb3lite_pkg::*;

  localparam logic [31:0] CPU_A = 32'hC000_0000;
  localparam logic [31:0] CPU_D = 32'hCCCC_0001;
  localparam logic [31:0] DMA_D = 32'hDDDD_0002;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cpu_req, dma_req, cpu_grant, dma_grant;
  logic [31:0] cpu_HADDR, dma_HADDR, cpu_HWDATA, dma_HWDATA, HADDR, HWDATA;
  HTRANS_state cpu_HTRANS, dma_HTRANS, HTRANS;
  HBURST_Type  cpu_HBURST, dma_HBURST, HBURST;
  logic        cpu_HWRITE, dma_HWRITE, HWRITE, HREADY;
  logic [2:0]  cpu_HSIZE, dma_HSIZE, HSIZE;
  arb_owner_e  HMASTER, data_owner;

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;

  ahb_cpu_dma_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_req(cpu_req), .dma_req(dma_req), .cpu_grant(cpu_grant), .dma_grant(dma_grant),
    .cpu_HADDR(cpu_HADDR), .dma_HADDR(dma_HADDR),
    .cpu_HTRANS(cpu_HTRANS), .dma_HTRANS(dma_HTRANS),
    .cpu_HBURST(cpu_HBURST), .dma_HBURST(dma_HBURST),
    .cpu_HWRITE(cpu_HWRITE), .dma_HWRITE(dma_HWRITE),
    .cpu_HSIZE(cpu_HSIZE), .dma_HSIZE(dma_HSIZE),
    .cpu_HWDATA(cpu_HWDATA), .dma_HWDATA(dma_HWDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HMASTER(HMASTER), .data_owner(data_owner)
  );

  typedef struct {
    logic        creq;
    logic        dreq;
    HTRANS_state ctrans;
    HTRANS_state dtrans;
    HBURST_Type  dburst;
    logic [31:0] daddr;
    logic        hready;
    arb_owner_e  exp_own;
    HTRANS_state exp_trans;
    logic [31:0] exp_addr;
    arb_owner_e  exp_down;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_owner(input string tag, input arb_owner_e own);
    check({tag, " HMASTER"}, 32'(HMASTER), 32'(own));
    check({tag, " grants"}, {30'd0, cpu_grant, dma_grant}, (own == DMA) ? 32'd1 : 32'd2);
  endtask

  initial begin
    arb_owner_e exp_seq[5];
    HRESETn = 1'b0; HREADY = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b0;
    cpu_HADDR = CPU_A; dma_HADDR = 32'h0;
    cpu_HTRANS = IDLE; dma_HTRANS = IDLE;
    cpu_HBURST = SINGLE; dma_HBURST = SINGLE;
    cpu_HWRITE = 1'b1; dma_HWRITE = 1'b1;
    cpu_HSIZE = 3'd2; dma_HSIZE = 3'd2;
    cpu_HWDATA = CPU_D; dma_HWDATA = DMA_D;

    //          creq  dreq  ctrans  dtrans  dburst  daddr        rdy   own  trans   addr         down cnt
    vecs[0]  = '{1'b0, 1'b0, IDLE,   IDLE,   SINGLE, 32'h0,       1'b1, CPU, IDLE,   CPU_A,       CPU, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, IDLE,   IDLE,   SINGLE, 32'h0,       1'b1, CPU, IDLE,   CPU_A,       CPU, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, IDLE,   NONSEQ, SINGLE, 32'h100,     1'b1, DMA, NONSEQ, 32'h100,     CPU, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, IDLE,   IDLE,   SINGLE, 32'h104,     1'b1, DMA, IDLE,   32'h104,     DMA, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, IDLE,   NONSEQ, INCR4,  32'h200,     1'b1, DMA, NONSEQ, 32'h200,     DMA, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, NONSEQ, SEQ,    INCR4,  32'h204,     1'b1, DMA, SEQ,    32'h204,     DMA, 4'd3};
    vecs[6]  = '{1'b1, 1'b1, NONSEQ, SEQ,    INCR4,  32'h208,     1'b0, DMA, SEQ,    32'h208,     DMA, 4'd2};
    vecs[7]  = '{1'b1, 1'b1, NONSEQ, SEQ,    INCR4,  32'h208,     1'b1, DMA, SEQ,    32'h208,     DMA, 4'd2};
    vecs[8]  = '{1'b1, 1'b1, NONSEQ, BUSY,   INCR4,  32'h20C,     1'b1, DMA, BUSY,   32'h20C,     DMA, 4'd1};
    vecs[9]  = '{1'b1, 1'b1, NONSEQ, SEQ,    INCR4,  32'h20C,     1'b0, DMA, SEQ,    32'h20C,     DMA, 4'd1};
    vecs[10] = '{1'b1, 1'b1, NONSEQ, SEQ,    INCR4,  32'h20C,     1'b1, DMA, SEQ,    32'h20C,     DMA, 4'd1};
    vecs[11] = '{1'b1, 1'b0, NONSEQ, IDLE,   SINGLE, 32'h210,     1'b1, DMA, IDLE,   32'h210,     DMA, 4'd0};
    vecs[12] = '{1'b1, 1'b0, NONSEQ, IDLE,   SINGLE, 32'h0,       1'b1, CPU, NONSEQ, CPU_A,       DMA, 4'd0};
    vecs[13] = '{1'b1, 1'b0, IDLE,   IDLE,   SINGLE, 32'h0,       1'b1, CPU, IDLE,   CPU_A,       CPU, 4'd0};

    // Reset state while held in reset.
    repeat (2) @(negedge HCLK);
    check_owner("reset", CPU);
    check("reset data_owner", 32'(data_owner), 32'(CPU));
    check("reset HTRANS", 32'(HTRANS), 32'(IDLE));
    check("reset count", 32'(dut.beat_count), 32'd0);
    HRESETn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge HCLK);
      cpu_req = vecs[i].creq; dma_req = vecs[i].dreq;
      cpu_HTRANS = vecs[i].ctrans; dma_HTRANS = vecs[i].dtrans;
      dma_HBURST = vecs[i].dburst; dma_HADDR = vecs[i].daddr;
      HREADY = vecs[i].hready;
      #1;
      check_owner($sformatf("vec%0d", i), vecs[i].exp_own);
      check($sformatf("vec%0d HTRANS", i), 32'(HTRANS), 32'(vecs[i].exp_trans));
      check($sformatf("vec%0d HADDR", i), HADDR, vecs[i].exp_addr);
      check($sformatf("vec%0d data_owner", i), 32'(data_owner), 32'(vecs[i].exp_down));
      check($sformatf("vec%0d HWDATA", i), HWDATA, (vecs[i].exp_down == DMA) ? DMA_D : CPU_D);
      check($sformatf("vec%0d count", i), 32'(dut.beat_count), 32'(vecs[i].exp_cnt));
    end

    // Contention: both request; each NONSEQ single is followed by an IDLE arbitration cycle.
    exp_seq[0] = CPU;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[1] = DMA; exp_seq[2] = CPU; exp_seq[3] = DMA; exp_seq[4] = CPU;
`else
    exp_seq[1] = DMA; exp_seq[2] = DMA; exp_seq[3] = DMA; exp_seq[4] = DMA;
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge HCLK);
      cpu_req = 1'b1; dma_req = 1'b1; HREADY = 1'b1;
      cpu_HTRANS = NONSEQ; dma_HTRANS = NONSEQ; dma_HBURST = SINGLE;
      #1;
      check_owner($sformatf("contend%0d", k), exp_seq[k]);
      check($sformatf("contend%0d HTRANS", k), 32'(HTRANS), 32'(NONSEQ));
      @(negedge HCLK);
      cpu_HTRANS = IDLE; dma_HTRANS = IDLE;
      #1;
      check_owner($sformatf("contend%0d hold", k), exp_seq[k]);
    end

    // Reset during beat 3 of a DMA INCR8.
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b1; cpu_HTRANS = IDLE; dma_HTRANS = IDLE;
    @(negedge HCLK);
    dma_HTRANS = NONSEQ; dma_HBURST = INCR8; dma_HADDR = 32'h300;
    #1;
    check_owner("incr8 start", DMA);
    @(negedge HCLK);
    dma_HTRANS = SEQ; dma_HADDR = 32'h304;
    @(negedge HCLK);
    dma_HADDR = 32'h308;
    #1;
    check("incr8 beat3 count", 32'(dut.beat_count), 32'd6);
    check("incr8 beat3 HADDR", HADDR, 32'h308);
    HRESETn = 1'b0;
    #1;
    check_owner("midreset", CPU);
    check("midreset count", 32'(dut.beat_count), 32'd0);
    check("midreset HTRANS", 32'(HTRANS), 32'(IDLE));
    check("midreset data_owner", 32'(data_owner), 32'(CPU));
    @(negedge HCLK);
    dma_req = 1'b0; dma_HTRANS = IDLE;
    HRESETn = 1'b1;
    @(negedge HCLK);
    #1;
    check_owner("after reset", CPU);
    check("after reset HWDATA", HWDATA, CPU_D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
